// File: rtl/serial_perceptron_if.sv
// Handshake, weight-load and result bundle for serial_perceptron.
// Optional feature macro: SERIAL_PERCEPTRON_LEARN_EN adds the in_label/in_train training inputs.
// slave = perceptron side, master = host/testbench side.
interface serial_perceptron_if #(
    parameter int N_IN  = 7,
    parameter int W_W   = 8,
    parameter int ACC_W = W_W + $clog2(N_IN + 1),
    parameter int AW    = $clog2(N_IN + 1)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N_IN-1:0]         in_vec;
    logic                    w_we;
    logic [AW-1:0]           w_addr;
    logic signed [W_W-1:0]   w_wdata;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic                    out_class;
`ifdef SERIAL_PERCEPTRON_LEARN_EN
    logic                    in_label;
    logic                    in_train;
`endif

    modport slave (
        input  in_valid, in_vec, w_we, w_addr, w_wdata, out_ready,
`ifdef SERIAL_PERCEPTRON_LEARN_EN
        input  in_label, in_train,
`endif
        output in_ready, out_valid, out_sum, out_class
    );

    modport master (
        output in_valid, in_vec, w_we, w_addr, w_wdata, out_ready,
`ifdef SERIAL_PERCEPTRON_LEARN_EN
        output in_label, in_train,
`endif
        input  in_ready, out_valid, out_sum, out_class
    );
endinterface

// File: rtl/serial_perceptron.sv
// Bit-serial binary perceptron: sums bias plus the weight of every set feature,
// one feature per clock, and reports the signed sum and its sign-derived class.
// Optional feature macro: SERIAL_PERCEPTRON_LEARN_EN enables on-chip perceptron-rule
// training (UPDATE state, saturating +/-1 steps on weights and bias).
//
// state  | meaning
// IDLE   | in_ready high; weight writes accepted; accept captures the vector
// ACCUM  | scan feature idx 0..N_IN-1, add weight when the feature bit is set
// DONE   | first cycle registers the result, then out_valid held until out_ready
// UPDATE | (learn only) idx 0..N_IN-1 steps set weights, idx N_IN steps bias
module serial_perceptron #(
    parameter int N_IN  = 7,
    parameter int W_W   = 8,
    parameter int ACC_W = W_W + $clog2(N_IN + 1),
    parameter int AW    = $clog2(N_IN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_perceptron_if.slave  pif
);

`ifdef SERIAL_PERCEPTRON_LEARN_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE, S_UPDATE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
`endif

    localparam logic [AW-1:0] IDX_LAST  = AW'(N_IN - 1);
    localparam logic [AW-1:0] ADDR_BIAS = AW'(N_IN);

    state_t                  state_q;
    logic [N_IN-1:0]         vec_q;
    logic [AW-1:0]           idx_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [W_W-1:0]   w_q [N_IN];
    logic signed [W_W-1:0]   bias_q;
    logic signed [W_W-1:0]   bias_d;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] out_sum_q;
    logic                    out_class_q;
    logic                    wr_en;
    logic                    accept;

`ifdef SERIAL_PERCEPTRON_LEARN_EN
    localparam logic signed [W_W-1:0] W_MAX = {1'b0, {(W_W-1){1'b1}}};
    localparam logic signed [W_W-1:0] W_MIN = {1'b1, {(W_W-1){1'b0}}};

    logic label_q;
    logic train_q;

    function automatic logic signed [W_W-1:0] sat_step(input logic signed [W_W-1:0] v,
                                                      input logic up);
        logic signed [W_W-1:0] r;
        r = v;
        if (up) begin
            if (v != W_MAX) r = v + W_W'(1);
        end else begin
            if (v != W_MIN) r = v - W_W'(1);
        end
        return r;
    endfunction
`endif

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [W_W-1:0] v);
        return {{(ACC_W-W_W){v[W_W-1]}}, v};
    endfunction

    assign pif.in_ready  = in_ready_q;
    assign pif.out_valid = out_valid_q;
    assign pif.out_sum   = out_sum_q;
    assign pif.out_class = out_class_q;

    // Write decode, same-cycle bias forwarding for accept, and the scan adder.
    always_comb begin
        wr_en  = (state_q == S_IDLE) && pif.w_we;
        accept = pif.in_valid && in_ready_q;
        bias_d = bias_q;
        if (wr_en && (pif.w_addr == ADDR_BIAS)) bias_d = pif.w_wdata;
        acc_d = acc_q;
        if (vec_q[idx_q]) acc_d = acc_q + sext(w_q[idx_q]);
    end

    // Sequencer, weight store and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_class_q <= 1'b0;
`ifdef SERIAL_PERCEPTRON_LEARN_EN
            label_q     <= 1'b0;
            train_q     <= 1'b0;
`endif
        end else begin
            if (wr_en) begin
                if (pif.w_addr < ADDR_BIAS) w_q[pif.w_addr] <= pif.w_wdata;
                else if (pif.w_addr == ADDR_BIAS) bias_q <= pif.w_wdata;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        vec_q      <= pif.in_vec;
                        acc_q      <= sext(bias_d);
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ACCUM;
`ifdef SERIAL_PERCEPTRON_LEARN_EN
                        label_q    <= pif.in_label;
                        train_q    <= pif.in_train;
`endif
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_d;
                    if (idx_q == IDX_LAST) state_q <= S_DONE;
                    else idx_q <= idx_q + AW'(1);
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_sum_q   <= acc_q;
                        out_class_q <= ~acc_q[ACC_W-1];
                    end else if (pif.out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef SERIAL_PERCEPTRON_LEARN_EN
                        if (train_q && (label_q != out_class_q)) begin
                            idx_q   <= '0;
                            state_q <= S_UPDATE;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
`else
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
`endif
                    end
                end
`ifdef SERIAL_PERCEPTRON_LEARN_EN
                S_UPDATE: begin
                    if (idx_q == ADDR_BIAS) begin
                        bias_q     <= sat_step(bias_q, label_q);
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        if (vec_q[idx_q]) w_q[idx_q] <= sat_step(w_q[idx_q], label_q);
                        idx_q <= idx_q + AW'(1);
                    end
                end
`endif
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_perceptron.sv
// Self-checking bench for serial_perceptron: directed cases followed by random
// weight loads / vectors, checked against an integer reference model.
// Define SERIAL_PERCEPTRON_LEARN_EN to also exercise the training path.
module tb_serial_perceptron;
    localparam int N_IN  = 7;
    localparam int W_W   = 8;
    localparam int ACC_W = W_W + $clog2(N_IN + 1);
    localparam int AW    = $clog2(N_IN + 1);
`ifdef SERIAL_PERCEPTRON_LEARN_EN
    localparam bit LEARN = 1'b1;
`else
    localparam bit LEARN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   mw [N_IN];
    int   mb;

    serial_perceptron_if #(.N_IN(N_IN), .W_W(W_W), .ACC_W(ACC_W), .AW(AW)) pif ();

    serial_perceptron #(.N_IN(N_IN), .W_W(W_W), .ACC_W(ACC_W), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_sum(input logic [N_IN-1:0] v);
        int s;
        s = mb;
        for (int i = 0; i < N_IN; i++) if (v[i]) s += mw[i];
        return s;
    endfunction

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N_IN; i++) mw[i] = 0;
        mb = 0;
    endtask

    task automatic wr(input int addr, input int data);
        pif.w_we    = 1'b1;
        pif.w_addr  = AW'(addr);
        pif.w_wdata = W_W'(data);
        tick();
        pif.w_we = 1'b0;
        if (addr < N_IN) mw[addr] = data;
        else if (addr == N_IN) mb = data;
    endtask

    // One classification: accept, latency, result, hold, handshake, optional training.
    task automatic run(input logic [N_IN-1:0] vec, input int hold, input bit drop_wr,
                       input bit lbl, input bit trn);
        int n;
        int es;
        bit ec;
        es = exp_sum(vec);
        ec = (es >= 0);
        chk("ready_idle", pif.in_ready, 1);
        pif.in_valid = 1'b1;
        pif.in_vec   = vec;
`ifdef SERIAL_PERCEPTRON_LEARN_EN
        pif.in_label = lbl;
        pif.in_train = trn;
`endif
        tick();
        pif.in_valid = 1'b0;
        pif.in_vec   = N_IN'($urandom);
        chk("ready_busy", pif.in_ready, 0);
        n = 0;
        while (pif.out_valid !== 1'b1 && n < 20) begin
            if (drop_wr && n == 2) begin
                pif.w_we = 1'b1; pif.w_addr = AW'($urandom_range(0, N_IN));
                pif.w_wdata = W_W'($urandom);
            end
            tick();
            pif.w_we = 1'b0;
            n++;
        end
        chk("latency", n, N_IN + 1);
        chk("sum", pif.out_sum, es);
        chk("class", pif.out_class, ec);
        for (int i = 0; i < hold; i++) begin
            if (drop_wr && i == 0) begin
                pif.w_we = 1'b1; pif.w_addr = 3'd0; pif.w_wdata = W_W'($urandom);
            end
            tick();
            pif.w_we = 1'b0;
            chk("hold_valid", pif.out_valid, 1);
            chk("hold_sum", pif.out_sum, es);
            chk("hold_ready", pif.in_ready, 0);
        end
        pif.out_ready = 1'b1;
        tick();
        pif.out_ready = 1'b0;
        chk("valid_drop", pif.out_valid, 0);
        chk("sum_retained", pif.out_sum, es);
        if (LEARN && trn && (lbl != ec)) begin
            for (int i = 0; i < N_IN; i++) if (vec[i]) mw[i] = sat(mw[i] + (lbl ? 1 : -1));
            mb = sat(mb + (lbl ? 1 : -1));
            n = 0;
            while (pif.in_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("update_len", n, N_IN + 1);
        end else begin
            chk("ready_back", pif.in_ready, 1);
        end
    endtask

    initial begin
        int op;
        pif.in_valid  = 1'b0;
        pif.in_vec    = '0;
        pif.w_we      = 1'b0;
        pif.w_addr    = '0;
        pif.w_wdata   = '0;
        pif.out_ready = 1'b0;
`ifdef SERIAL_PERCEPTRON_LEARN_EN
        pif.in_label  = 1'b0;
        pif.in_train  = 1'b0;
`endif
        model_clear();
        #12;
        chk("rst_in_ready", pif.in_ready, 1);
        chk("rst_out_valid", pif.out_valid, 0);
        chk("rst_out_sum", pif.out_sum, 0);
        chk("rst_out_class", pif.out_class, 0);
        rst_n = 1'b1;
        tick();

        // zero weights, all features: sum 0 -> class 1
        run(7'h7F, 0, 1'b0, 1'b0, 1'b0);

        // w[i]=i+1, bias=-10
        for (int i = 0; i < N_IN; i++) wr(i, i + 1);
        wr(N_IN, -10);
        run(7'b0000101, 0, 1'b0, 1'b0, 1'b0);
        run(7'h7F, 1, 1'b0, 1'b0, 1'b0);

        // stall in DONE with dropped writes, then confirm weights untouched
        run(7'h01, 5, 1'b1, 1'b0, 1'b0);
        run(7'h01, 0, 1'b0, 1'b0, 1'b0);
        run(7'h7F, 0, 1'b0, 1'b0, 1'b0);

        // write and accept in the same cycle: new bias must be used
        pif.w_we = 1'b1; pif.w_addr = AW'(N_IN); pif.w_wdata = W_W'(-3);
        pif.in_valid = 1'b1; pif.in_vec = 7'h02;
        mb = -3;
        chk("same_cycle_sum_model", exp_sum(7'h02), mw[1] - 3);
        tick();
        pif.w_we = 1'b0; pif.in_valid = 1'b0;
        for (int i = 0; i < N_IN; i++) tick();
        tick();
        chk("same_cycle_valid", pif.out_valid, 1);
        chk("same_cycle_sum", pif.out_sum, exp_sum(7'h02));
        pif.out_ready = 1'b1; tick(); pif.out_ready = 1'b0;

        // async reset during third ACCUM cycle
        pif.in_valid = 1'b1; pif.in_vec = 7'h7F;
        tick();
        pif.in_valid = 1'b0;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", pif.out_valid, 0);
        chk("abort_in_ready", pif.in_ready, 1);
        model_clear();
        #2 rst_n = 1'b1;
        tick();
        run(7'h7F, 0, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_PERCEPTRON_LEARN_EN
        // zero weights, label 0 mismatch -> w[0]=-1, bias=-1
        run(7'h01, 0, 1'b0, 1'b0, 1'b1);
        chk("learn_w0_model", mw[0], -1);
        run(7'h00, 0, 1'b0, 1'b0, 1'b0);
        run(7'h01, 0, 1'b0, 1'b0, 1'b0);
        run(7'h7E, 0, 1'b0, 1'b0, 1'b0);
        // negative saturation boundary
        wr(0, -128); wr(N_IN, -128);
        run(7'h01, 0, 1'b0, 1'b1, 1'b1);
        run(7'h00, 0, 1'b0, 1'b0, 1'b0);
        run(7'h01, 0, 1'b0, 1'b0, 1'b0);
        // positive boundary: +1 step holds at 127
        wr(0, 127); wr(N_IN, -128);
        run(7'h01, 0, 1'b0, 1'b1, 1'b1);
        run(7'h01, 0, 1'b0, 1'b0, 1'b0);
        // 127 with label 0 mismatch steps down
        wr(0, 127); wr(N_IN, 0);
        run(7'h01, 0, 1'b0, 1'b0, 1'b1);
        run(7'h01, 0, 1'b0, 1'b0, 1'b0);
        run(7'h00, 0, 1'b0, 1'b0, 1'b0);
        // correctly classified training vector leaves weights alone
        run(7'h01, 0, 1'b0, 1'b1, 1'b1);
`endif

        // randomized loads and classifications
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                wr($urandom_range(0, N_IN), $urandom_range(0, 255) - 128);
            end else begin
                run(N_IN'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
